// File: rtl/game_pkg.sv
// Shared types and constants for the runner game controller.
// Screen extents, lanes, shape codes and sequencer states.
package game_pkg;

    typedef enum logic [3:0] {
        FLOORS,
        IDLE,
        WAIT,
        LOAD,
        ERASE,
        TREE,
        MAN,
        CHECK,
        OVER,
        DEAD
    } state_t;

    typedef logic [1:0] shape_t;

    localparam shape_t SHAPE_TOP_GAP = 2'b00;
    localparam shape_t SHAPE_TOP_ALT = 2'b01;
    localparam shape_t SHAPE_BOT_GAP = 2'b10;
    localparam shape_t SHAPE_WALL    = 2'b11;

    typedef struct packed {
        shape_t top;
        shape_t mid;
        shape_t bottom;
    } shapes_t;

    localparam shapes_t RESET_SHAPES = '{
        top:    SHAPE_TOP_GAP,
        mid:    SHAPE_BOT_GAP,
        bottom: SHAPE_WALL
    };

    localparam logic [7:0] SCREEN_W   = 8'd160;
    localparam logic [6:0] SCREEN_H   = 7'd120;
    localparam logic [7:0] SPEED      = 8'd2;
    localparam logic [7:0] TREE_START = SCREEN_W - 8'd4;
    localparam logic [7:0] MAN_X      = 8'd25;
    localparam logic [6:0] LANE0_Y    = 7'd28;
    localparam logic [6:0] LANE1_Y    = 7'd68;
    localparam logic [6:0] LANE2_Y    = SCREEN_H - 7'd12;

    function automatic logic [6:0] lane_y(input logic [1:0] lane);
        logic [6:0] y;
        unique case (lane)
            2'd0:    y = LANE0_Y;
            2'd1:    y = LANE1_Y;
            default: y = LANE2_Y;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control bundle between the frame sequencer and the drawing datapath.
// The sequencer is master; the datapath returns finish levels.
interface frame_sequencer_if;
    import game_pkg::*;

    logic        drawing_floors;
    logic        erase;
    logic        draw_tree;
    logic        draw_man;
    logic        gameover;
    logic        draw_floors_finish;
    logic        erase_finish;
    logic        draw_tree_finish;
    logic        draw_man_finish;
    logic        draw_gameover_finish;
    logic        ld_x;
    logic        ld_y;
    logic        ld_man_style;
    logic        ld_shape;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic        man_style;
    shape_t      top;
    shape_t      mid;
    shape_t      bottom;
    logic [15:0] score;

    modport master (
        output drawing_floors, erase, draw_tree, draw_man, gameover,
        output ld_x, ld_y, ld_man_style, ld_shape,
        output x_out, y_out, man_style, top, mid, bottom, score,
        input  draw_floors_finish, erase_finish, draw_tree_finish,
        input  draw_man_finish, draw_gameover_finish
    );

    modport slave (
        input  drawing_floors, erase, draw_tree, draw_man, gameover,
        input  ld_x, ld_y, ld_man_style, ld_shape,
        input  x_out, y_out, man_style, top, mid, bottom, score,
        output draw_floors_finish, erase_finish, draw_tree_finish,
        output draw_man_finish, draw_gameover_finish
    );

endinterface

// File: rtl/collision_check.sv
// Combinational runner/obstacle overlap test.
// Hit when the obstacle overlaps the runner columns and the lane shape blocks.
module collision_check
    import game_pkg::*;
(
    input  logic [7:0] tx,
    input  logic [1:0] lane,
    input  logic       man_style,
    input  shapes_t    shapes,
    output logic       hit
);

    logic [8:0] tx_p1;
    logic       in_col;
    shape_t     s;
    logic       bad;

    assign tx_p1  = {1'b0, tx} + 9'd1;
    assign in_col = (tx_p1 >= {1'b0, MAN_X}) &&
                    (tx <= MAN_X + 8'd6);

    always_comb begin
        unique case (lane)
            2'd0:    s = shapes.top;
            2'd1:    s = shapes.mid;
            default: s = shapes.bottom;
        endcase
    end

    // man_style 1 = upright: a bottom gap needs a crouch, a top gap forbids it
    always_comb begin
        bad = 1'b0;
        unique case (s)
            SHAPE_WALL:    bad = 1'b1;
            SHAPE_BOT_GAP: bad = man_style;
            SHAPE_TOP_GAP,
            SHAPE_TOP_ALT: bad = ~man_style;
        endcase
    end

    assign hit = in_col & bad;

endmodule

// File: rtl/frame_sequencer.sv
// Game controller: sequences floor init, per-frame draw phases and game over.
// Owns obstacle position, shapes, runner lane/posture and score.
module frame_sequencer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_crouch,
    input  logic [5:0]        shape_rnd,
    frame_sequencer_if.master dp
);

    state_t      state;
    logic        pend;
    logic [7:0]  tx;
    logic [1:0]  lane;
    logic [6:0]  y;
    logic        style;
    shapes_t     shp;
    logic [15:0] score;
    logic        floors, er, tr, mn, ov;
    logic        ld_x, ld_y, ld_ms, ld_sh;
    logic        hit;
    logic        wrap;
    logic        busy;
    logic [1:0]  lane_nx;

    collision_check u_cc (
        .tx        (tx),
        .lane      (lane),
        .man_style (style),
        .shapes    (shp),
        .hit       (hit)
    );

    assign wrap = tx < SPEED;
    assign busy = (state == LOAD) || (state == ERASE) ||
                  (state == TREE) || (state == MAN) ||
                  (state == CHECK);

    always_comb begin
        lane_nx = lane;
        unique case (1'b1)
            btn_up && !btn_down && lane != 2'd0:
                lane_nx = lane - 2'd1;
            btn_down && !btn_up && lane != 2'd2:
                lane_nx = lane + 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FLOORS;
            pend   <= 1'b0;
            tx     <= TREE_START;
            lane   <= 2'd2;
            y      <= LANE2_Y;
            style  <= 1'b1;
            shp    <= RESET_SHAPES;
            score  <= 16'd0;
            floors <= 1'b0;
            er     <= 1'b0;
            tr     <= 1'b0;
            mn     <= 1'b0;
            ov     <= 1'b0;
            ld_x   <= 1'b0;
            ld_y   <= 1'b0;
            ld_ms  <= 1'b0;
            ld_sh  <= 1'b0;
        end else begin
            ld_x  <= 1'b0;
            ld_y  <= 1'b0;
            ld_ms <= 1'b0;
            ld_sh <= 1'b0;
            // one tick of slack while a frame is being drawn
            if (frame_tick && busy)
                pend <= 1'b1;
            unique case (state)
                FLOORS: begin
                    floors <= ~dp.draw_floors_finish;
                    if (dp.draw_floors_finish)
                        state <= IDLE;
                end
                IDLE: if (start) state <= WAIT;
                WAIT: if (frame_tick || pend) begin
                    pend  <= 1'b0;
                    state <= LOAD;
                    ld_x  <= 1'b1;
                    ld_y  <= 1'b1;
                    ld_ms <= 1'b1;
                    if (wrap) begin
                        tx    <= TREE_START;
                        shp   <= shapes_t'(shape_rnd);
                        ld_sh <= 1'b1;
                        if (score != 16'hFFFF)
                            score <= score + 16'd1;
                    end else begin
                        tx <= tx - SPEED;
                    end
                    lane  <= lane_nx;
                    y     <= lane_y(lane_nx);
                    style <= ~btn_crouch;
                end
                LOAD: begin
                    state <= ERASE;
                    er    <= 1'b1;
                end
                ERASE: if (dp.erase_finish) begin
                    state <= TREE;
                    er    <= 1'b0;
                    tr    <= 1'b1;
                end
                TREE: if (dp.draw_tree_finish) begin
                    state <= MAN;
                    tr    <= 1'b0;
                    mn    <= 1'b1;
                end
                MAN: if (dp.draw_man_finish) begin
                    state <= CHECK;
                    mn    <= 1'b0;
                end
                CHECK: begin
                    if (hit) begin
                        state <= OVER;
                        ov    <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                OVER: if (dp.draw_gameover_finish) begin
                    state <= DEAD;
                    ov    <= 1'b0;
                end
                DEAD: ;
                default: state <= FLOORS;
            endcase
        end
    end

    assign dp.drawing_floors = floors;
    assign dp.erase          = er;
    assign dp.draw_tree      = tr;
    assign dp.draw_man       = mn;
    assign dp.gameover       = ov;
    assign dp.ld_x           = ld_x;
    assign dp.ld_y           = ld_y;
    assign dp.ld_man_style   = ld_ms;
    assign dp.ld_shape       = ld_sh;
    assign dp.x_out          = tx;
    assign dp.y_out          = y;
    assign dp.man_style      = style;
    assign dp.top            = shp.top;
    assign dp.mid            = shp.mid;
    assign dp.bottom         = shp.bottom;
    assign dp.score          = score;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a small game-state model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_frame_sequencer;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_crouch = 1'b0;
    logic [5:0] shape_rnd = 6'b00_00_10;

    frame_sequencer_if bus();

    frame_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start      (start),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_crouch (btn_crouch),
        .shape_rnd  (shape_rnd),
        .dp         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  m_tx = 8'd156;
    logic [1:0]  m_lane = 2'd2;
    logic        m_style = 1'b1;
    shapes_t     m_shp = '{top: 2'b00, mid: 2'b10, bottom: 2'b11};
    logic [15:0] m_score = 16'd0;
    logic        m_spawn = 1'b0;
    logic        ref_hit;
    int          ly [3] = '{28, 68, 108};

    collision_check u_ref (
        .tx        (m_tx),
        .lane      (m_lane),
        .man_style (m_style),
        .shapes    (m_shp),
        .hit       (ref_hit)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] reqs();
        return {1'b0, bus.drawing_floors, bus.erase,
                bus.draw_tree, bus.draw_man, bus.gameover};
    endfunction

    task automatic frame(input logic up, input logic dn,
                         input logic cr, input logic tk,
                         input int nt);
        logic [4:0] seq;
        int n;
        btn_up = up;
        btn_down = dn;
        btn_crouch = cr;
        m_spawn = (m_tx < 8'd2);
        if (m_spawn) begin
            m_tx = 8'd156;
            m_shp = shapes_t'(shape_rnd);
            if (m_score != 16'hFFFF) m_score++;
        end else begin
            m_tx = m_tx - 8'd2;
        end
        if (up && !dn && m_lane != 2'd0) m_lane--;
        else if (dn && !up && m_lane != 2'd2) m_lane++;
        m_style = ~cr;
        if (tk) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end else begin
            @(negedge clk);
        end
        n = 0;
        while (!bus.ld_x && n < 4) begin
            @(negedge clk);
            n++;
        end
        seq[4] = bus.ld_x & bus.ld_y & bus.ld_man_style;
        check("x", bus.x_out, m_tx);
        check("y", bus.y_out, ly[m_lane]);
        check("ld_shape", bus.ld_shape, m_spawn);
        check("score", bus.score, m_score);
        @(negedge clk);
        seq[3] = bus.erase & ~bus.ld_x;
        for (int i = 0; i < nt; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        bus.erase_finish = 1'b1;
        @(negedge clk);
        bus.erase_finish = 1'b0;
        seq[2] = bus.draw_tree & ~bus.erase;
        bus.draw_tree_finish = 1'b1;
        @(negedge clk);
        bus.draw_tree_finish = 1'b0;
        seq[1] = bus.draw_man & ~bus.draw_tree;
        bus.draw_man_finish = 1'b1;
        @(negedge clk);
        bus.draw_man_finish = 1'b0;
        seq[0] = (reqs() == 6'd0);
        @(negedge clk);
        check("seq", seq, 5'h1F);
        check("hit", bus.gameover, ref_hit);
    endtask

    int cnt;
    int g;

    initial begin
        bus.draw_floors_finish = 1'b0;
        bus.erase_finish = 1'b0;
        bus.draw_tree_finish = 1'b0;
        bus.draw_man_finish = 1'b0;
        bus.draw_gameover_finish = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req", reqs(), 6'd0);
        check("rst_x", bus.x_out, 8'd156);
        check("rst_y", bus.y_out, 7'd108);
        check("rst_score", bus.score, 16'd0);
        check("rst_style", bus.man_style, 1'b1);
        check("rst_shapes", {bus.top, bus.mid, bus.bottom}, 6'b00_10_11);
        reset_n = 1'b1;
        @(negedge clk);
        check("floors_on", bus.drawing_floors, 1'b1);
        repeat (640) @(negedge clk);
        check("floors_hold", bus.drawing_floors, 1'b1);
        bus.draw_floors_finish = 1'b1;
        @(negedge clk);
        bus.draw_floors_finish = 1'b0;
        check("floors_off", reqs(), 6'd0);
        check("idle_x", bus.x_out, 8'd156);
        check("idle_y", bus.y_out, 7'd108);
        check("idle_score", bus.score, 16'd0);

        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ld_x || bus.erase) cnt++;
        end
        check("idle_tick_ignored", cnt, 0);

        frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("first_x", bus.x_out, 8'd154);
        frame(1'b1, 1'b1, 1'b0, 1'b1, 0);
        check("updown_lane", bus.y_out, 7'd108);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("lane1", bus.y_out, 7'd68);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("lane0_clamp", bus.y_out, 7'd28);

        frame(1'b0, 1'b0, 1'b0, 1'b1, 2);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("pending_x", bus.x_out, 8'd142);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ld_x) cnt++;
        end
        check("one_pending_only", cnt, 0);

        for (int f = 8; f <= 78; f++)
            frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("pre_wrap_x", bus.x_out, 8'd0);
        frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("wrap_x", bus.x_out, 8'd156);
        check("wrap_score", bus.score, 16'd1);
        check("wrap_shapes", {bus.top, bus.mid, bus.bottom}, 6'b00_00_10);

        frame(1'b0, 1'b1, 1'b0, 1'b1, 0);
        frame(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("lane2", bus.y_out, 7'd108);
        g = 0;
        while (m_tx != 8'd28 && g < 200) begin
            frame(1'b0, 1'b0, 1'b1, 1'b1, 0);
            g++;
        end
        check("crouch28_x", bus.x_out, 8'd28);
        check("crouch28_nohit", bus.gameover, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("crouch_next", bus.x_out, 8'd26);
        g = 0;
        while (m_score < 16'd2 && g < 200) begin
            frame(1'b0, 1'b0, 1'b1, 1'b1, 0);
            g++;
        end
        g = 0;
        while (m_tx != 8'd30 && g < 200) begin
            frame(1'b0, 1'b0, 1'b1, 1'b1, 0);
            g++;
        end
        frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("stand28_x", bus.x_out, 8'd28);
        check("stand28_hit", bus.gameover, 1'b1);
        repeat (3) @(negedge clk);
        check("over_hold", reqs(), 6'b000001);
        bus.draw_gameover_finish = 1'b1;
        @(negedge clk);
        bus.draw_gameover_finish = 1'b0;
        check("dead_req", reqs(), 6'd0);
        cnt = 0;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            frame_tick = (i % 3 == 0);
            @(negedge clk);
            if (reqs() != 6'd0 || bus.ld_x) cnt++;
        end
        start = 1'b0;
        frame_tick = 1'b0;
        check("dead_absorb", cnt, 0);
        check("dead_score", bus.score, 16'd2);

        reset_n = 1'b0;
        #1;
        check("rst2_score", bus.score, 16'd0);
        check("rst2_x", bus.x_out, 8'd156);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst2_floors", bus.drawing_floors, 1'b1);
        bus.draw_floors_finish = 1'b1;
        @(negedge clk);
        bus.draw_floors_finish = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("r3_ld", bus.ld_x, 1'b1);
        @(negedge clk);
        check("r3_erase", bus.erase, 1'b1);
        bus.erase_finish = 1'b1;
        @(negedge clk);
        bus.erase_finish = 1'b0;
        check("r3_tree", reqs(), 6'b000100);
        reset_n = 1'b0;
        #1;
        check("tree_rst_req", reqs(), 6'd0);
        check("tree_rst_x", bus.x_out, 8'd156);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("tree_rst_floors", reqs(), 6'b010000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
